// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer
// Upstream command stage for a master-slave JK flip-flop. Commands {op, cnt}
// are buffered in a circular FIFO and replayed onto the flip-flop's j/k inputs,
// each op held for cnt+1 clocks. A cycle-accurate model of the flip-flop's
// master state (q_pred) is kept alongside.
//
// Ports:
//   clk        rising-edge clock shared with the flip-flop master
//   rst        asynchronous reset, active-high
//   in_valid   command present;   in_ready  FIFO not full
//   in_op      00 hold, 01 reset, 10 set, 11 toggle ({j,k})
//   in_cnt     repeat field, op driven for in_cnt+1 cycles
//   j, k       registered drive to the flip-flop
//   q_pred     predicted master state after the last applied edge
//   busy       FIFO non-empty or a command running
//   cmd_done   high in the final drive cycle of each command
//   fifo_level number of stored entries
//
// Optional feature (macro JK_CHECK_EN): adds qs_in (slave output fed back)
// and a sticky mismatch flag comparing qs_in with q_pred as it stood before
// each rising edge. The first edge after reset is not compared.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [CNT_W-1:0]         in_cnt,
    output logic                     j,
    output logic                     k,
    output logic                     q_pred,
    output logic                     busy,
    output logic                     cmd_done,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef JK_CHECK_EN
    ,
    input  logic                     qs_in,
    output logic                     mismatch
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + CNT_W;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_s;
    logic             full_s, empty_s, push_s, pop_s;
    logic [EW-1:0]    head_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             j_q, j_d, k_q, k_d;
    logic             q_pred_q, q_pred_d;
    logic             cmd_done_q, cmd_done_d;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level_s = wr_ptr_q - rd_ptr_q;
    assign full_s  = (level_s == FULL_LVL);
    assign empty_s = (level_s == '0);
    // Push depends only on the full flag; a same-cycle pop never frees a slot.
    assign push_s  = in_valid && !full_s;
    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

    // FIFO storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_op, in_cnt};
        end
    end

    // FIFO read/write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Next-state, drive and prediction logic.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        j_d      = j_q;
        k_d      = k_q;
        pop_s    = 1'b0;
        q_pred_d = q_pred_q;
        case (state_q)
            IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    j_d     = head_s[EW-1];
                    k_d     = head_s[EW-2];
                    rem_d   = head_s[CNT_W-1:0];
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - CNT_W'(1);
                end else if (!empty_s) begin
                    // Chain straight into the next command without a bubble.
                    pop_s = 1'b1;
                    j_d   = head_s[EW-1];
                    k_d   = head_s[EW-2];
                    rem_d = head_s[CNT_W-1:0];
                end else begin
                    state_d = IDLE;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
                rem_d   = '0;
            end
        endcase

        // The flip-flop master samples the j/k currently being driven.
        case ({j_q, k_q})
            2'b01:   q_pred_d = 1'b0;
            2'b10:   q_pred_d = 1'b1;
            2'b11:   q_pred_d = ~q_pred_q;
            default: q_pred_d = q_pred_q;
        endcase

        cmd_done_d = (state_d == RUN) && (rem_d == '0);
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            q_pred_q   <= 1'b0;
            cmd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            j_q        <= j_d;
            k_q        <= k_d;
            q_pred_q   <= q_pred_d;
            cmd_done_q <= cmd_done_d;
        end
    end

    assign in_ready   = !full_s;
    assign j          = j_q;
    assign k          = k_q;
    assign q_pred     = q_pred_q;
    assign cmd_done   = cmd_done_q;
    assign fifo_level = level_s;
    assign busy       = (state_q == RUN) || !empty_s;

`ifdef JK_CHECK_EN
    logic first_q;
    logic mismatch_q;

    // Sticky slave-vs-prediction compare; first edge out of reset is skipped
    // because the slave has not yet seen a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q    <= 1'b1;
            mismatch_q <= 1'b0;
        end else begin
            first_q <= 1'b0;
            if (!first_q && (qs_in != q_pred_q)) begin
                mismatch_q <= 1'b1;
            end else begin
                mismatch_q <= mismatch_q;
            end
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_cnt;
    logic       j, k, q_pred, busy, cmd_done;
    logic [2:0] fifo_level;
`ifdef JK_CHECK_EN
    logic       qs_slave;
    logic       qs_force;
    logic       qs_in;
    logic       mismatch;
`endif

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_cnt     (in_cnt),
        .j          (j),
        .k          (k),
        .q_pred     (q_pred),
        .busy       (busy),
        .cmd_done   (cmd_done),
        .fifo_level (fifo_level)
`ifdef JK_CHECK_EN
        ,
        .qs_in      (qs_in),
        .mismatch   (mismatch)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected {j,k,cmd_done} for every drive cycle, in order.
    logic [2:0] sb [$];
    logic       q_m;
    int         cyc = 0;
    int         first_cyc = -1;
    int         last_cyc = -1;
    int         n_pop = 0;
    logic [2:0] got_s, exp_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference flip-flop master: samples the j/k driven before each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) q_m <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q_m <= 1'b0;
                2'b10:   q_m <= 1'b1;
                2'b11:   q_m <= ~q_m;
                default: q_m <= q_m;
            endcase
        end
    end

`ifdef JK_CHECK_EN
    // Slave latch: takes the master value on the falling edge.
    always @(negedge clk or posedge rst) begin
        if (rst) qs_slave <= 1'b0;
        else     qs_slave <= q_pred;
    end
    assign qs_in = qs_slave ^ qs_force;
`endif

    // Output monitor: pops the scoreboard on every active drive cycle.
    always @(negedge clk) begin
        if (!rst) begin
            got_s = {j, k, cmd_done};
            if (got_s != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {29'd0, got_s}, 32'd0);
                end else begin
                    exp_s = sb.pop_front();
                    chk("drive", {29'd0, got_s}, {29'd0, exp_s});
                    n_pop++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end
            chk("q_pred", {31'd0, q_pred}, {31'd0, q_m});
            chk("level_range", {31'd0, (fifo_level <= 3'(DEPTH))}, 32'd1);
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [3:0] cnt);
        int t = 0;
        in_op    = op;
        in_cnt   = cnt;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("push_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i <= int'(cnt); i++) begin
            sb.push_back({op[1], op[0], (i == int'(cnt))});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_sb", sb.size(), 32'd0);
        chk("idle_jk", {30'd0, j, k}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_j"},     {31'd0, j},        32'd0);
        chk({tag, "_k"},     {31'd0, k},        32'd0);
        chk({tag, "_q"},     {31'd0, q_pred},   32'd0);
        chk({tag, "_busy"},  {31'd0, busy},     32'd0);
        chk({tag, "_done"},  {31'd0, cmd_done}, 32'd0);
        chk({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_cnt   = 4'd0;
`ifdef JK_CHECK_EN
        qs_force = 1'b0;
`endif
        #1;
        check_reset_state("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Set for 3 cycles.
        push_cmd(2'b10, 4'd2);
        wait_idle();

        // Three toggles, contiguous.
        first_cyc = -1;
        n_pop = 0;
        push_cmd(2'b11, 4'd0);
        push_cmd(2'b11, 4'd0);
        push_cmd(2'b11, 4'd1);
        wait_idle();
        chk("toggle_pops", n_pop, 32'd4);
        chk("toggle_contig", last_cyc - first_cyc, 32'd3);

        // Fill FIFO behind a long command.
        push_cmd(2'b10, 4'd15);
        push_cmd(2'b01, 4'd1);
        push_cmd(2'b11, 4'd0);
        push_cmd(2'b10, 4'd0);
        push_cmd(2'b00, 4'd0);
        chk("full_level", {29'd0, fifo_level}, 32'd4);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        in_op = 2'b11; in_cnt = 4'd3; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("refused_level", {29'd0, fifo_level}, 32'd4);
        begin
            int t = 0;
            while (!in_ready && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
        end
        chk("reopen_ready", {31'd0, in_ready}, 32'd1);
        chk("reopen_level", {29'd0, fifo_level}, 32'd3);
        wait_idle();

        // Nine commands through a 4-deep FIFO: pointer wrap, order kept.
        for (int i = 0; i < 9; i++) begin
            case (i % 3)
                0:       push_cmd(2'b01, 4'(i % 2));
                1:       push_cmd(2'b10, 4'(i % 3));
                default: push_cmd(2'b11, 4'd1);
            endcase
        end
        wait_idle();

        // Reset mid-command with three queued.
        push_cmd(2'b11, 4'd15);
        push_cmd(2'b10, 4'd1);
        push_cmd(2'b01, 4'd1);
        push_cmd(2'b10, 4'd1);
        chk("pre_rst_level", {29'd0, fifo_level}, 32'd3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("post_rst");

`ifdef JK_CHECK_EN
        push_cmd(2'b10, 4'd1);
        push_cmd(2'b11, 4'd2);
        wait_idle();
        chk("chk_clean", {31'd0, mismatch}, 32'd0);
        @(posedge clk); #1;
        qs_force = 1'b1;
        @(posedge clk); #1;
        qs_force = 1'b0;
        chk("chk_set", {31'd0, mismatch}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("chk_sticky", {31'd0, mismatch}, 32'd1);
        rst = 1'b1;
        #1;
        chk("chk_rst", {31'd0, mismatch}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
